// File: rtl/song_pkg.sv
// Shared types and defaults for the song playback sequencer.
package song_pkg;

    localparam int unsigned NumSongsDefault = 4;
    localparam int unsigned SongWDefault    = 2;

    typedef logic [SongWDefault-1:0] song_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StPlaying,
        StPaused,
        StFlush
    } state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/playback_controller.sv
// Sequencer turning button edges and song_done into play/song/reset_player for song_reader.
module playback_controller
    import song_pkg::*;
#(
    parameter int unsigned NUM_SONGS    = NumSongsDefault,
    parameter int unsigned SONG_W       = SongWDefault,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          AUTO_ADVANCE = 1'b1,
    parameter bit          LOOP         = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_btn,
    input  logic              next_btn,
    input  logic              prev_btn,
    input  logic              song_done,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              reset_player,
    output logic              playing,
    output logic              song_changed
);

    localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [SONG_W-1:0] LastSong = SONG_W'(NUM_SONGS - 1);

    logic play_rise, next_rise, prev_rise;

    btn_edge u_play_edge (.clk(clk), .reset(reset), .level(play_btn), .rise(play_rise));
    btn_edge u_next_edge (.clk(clk), .reset(reset), .level(next_btn), .rise(next_rise));
    btn_edge u_prev_edge (.clk(clk), .reset(reset), .level(prev_btn), .rise(prev_rise));

    state_e            state_q, state_d;
    state_e            ret_q, ret_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SONG_W-1:0] song_inc, song_dec, song_nav;
    logic              nav;

    assign song_inc = (song_q == LastSong) ? '0 : song_q + 1'b1;
    assign song_dec = (song_q == '0) ? LastSong : song_q - 1'b1;
    // Simultaneous next and prev cancel each other.
    assign nav      = next_rise ^ prev_rise;
    assign song_nav = next_rise ? song_inc : song_dec;

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        song_d  = song_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (nav) begin
                    song_d  = song_nav;
                    ret_d   = StIdle;
                    state_d = StFlush;
                end else if (play_rise) begin
                    state_d = StPlaying;
                end
            end
            StPlaying: begin
                if (song_done) begin
                    state_d = StFlush;
                    ret_d   = StIdle;
                    if (AUTO_ADVANCE && (LOOP || song_q != LastSong)) begin
                        song_d = song_inc;
                        ret_d  = StPlaying;
                    end
                end else if (nav) begin
                    song_d  = song_nav;
                    ret_d   = StPlaying;
                    state_d = StFlush;
                end else if (play_rise) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (nav) begin
                    song_d  = song_nav;
                    ret_d   = StIdle;
                    state_d = StFlush;
                end else if (play_rise) begin
                    state_d = StPlaying;
                end
            end
            StFlush: begin
                if (cnt_q == '0) begin
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StFlush && state_d == StFlush) begin
            cnt_d = CntW'(FLUSH_CYCLES - 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            ret_q        <= StIdle;
            song_q       <= '0;
            cnt_q        <= '0;
            play         <= 1'b0;
            reset_player <= 1'b0;
            playing      <= 1'b0;
            song_changed <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            song_q       <= song_d;
            cnt_q        <= cnt_d;
            play         <= (state_d == StPlaying);
            reset_player <= (state_d == StFlush);
            playing      <= (state_d == StPlaying);
            song_changed <= (song_d != song_q);
        end
    end

    assign song = song_q;

endmodule

// File: tb/tb_playback_controller.sv
// Table-driven scoreboard bench for playback_controller (LOOP=1 and LOOP=0 instances).
module tb_playback_controller;

    typedef logic [5:0] out_t; // {play, song[1:0], reset_player, playing, song_changed}

    typedef struct {
        logic [3:0] in;      // {play_btn, next_btn, prev_btn, song_done}
        out_t       exp;
        out_t       exp_nl;
        bit         chk_nl;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play_btn = 1'b0, next_btn = 1'b0, prev_btn = 1'b0, song_done = 1'b0;
    logic       play, reset_player, playing, song_changed;
    logic [1:0] song;
    logic       play_nl, reset_player_nl, playing_nl, song_changed_nl;
    logic [1:0] song_nl;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    playback_controller #(
        .NUM_SONGS(4), .SONG_W(2), .FLUSH_CYCLES(2), .AUTO_ADVANCE(1'b1), .LOOP(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .play_btn(play_btn), .next_btn(next_btn),
        .prev_btn(prev_btn), .song_done(song_done), .play(play), .song(song),
        .reset_player(reset_player), .playing(playing), .song_changed(song_changed)
    );

    playback_controller #(
        .NUM_SONGS(4), .SONG_W(2), .FLUSH_CYCLES(2), .AUTO_ADVANCE(1'b1), .LOOP(1'b0)
    ) dut_nl (
        .clk(clk), .reset(reset), .play_btn(play_btn), .next_btn(next_btn),
        .prev_btn(prev_btn), .song_done(song_done), .play(play_nl), .song(song_nl),
        .reset_player(reset_player_nl), .playing(playing_nl), .song_changed(song_changed_nl)
    );

    function automatic out_t o(bit p, int s, bit r, bit y, bit c);
        logic [1:0] s2;
        s2 = 2'(s);
        return {p, s2, r, y, c};
    endfunction

    function automatic out_t act_main();
        return {play, song, reset_player, playing, song_changed};
    endfunction

    function automatic out_t act_nl();
        return {play_nl, song_nl, reset_player_nl, playing_nl, song_changed_nl};
    endfunction

    task automatic cmp(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {play,song,rst_pl,playing,chg}=%b required %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] in, input out_t exp);
        vecs.push_back('{in, exp, exp, 1'b0});
    endtask

    task automatic drive(input logic [3:0] in);
        {play_btn, next_btn, prev_btn, song_done} = in;
    endtask

    initial begin
        vec_t v;
        // Test 1: play from idle
        add(4'b1000, o(1, 0, 0, 1, 0));
        add(4'b0000, o(1, 0, 0, 1, 0));
        // Walk up to song 3 while playing, checking flush length each time
        add(4'b0100, o(0, 1, 1, 0, 1));
        add(4'b0000, o(0, 1, 1, 0, 0));
        add(4'b0000, o(1, 1, 0, 1, 0));
        add(4'b0100, o(0, 2, 1, 0, 1));
        add(4'b0000, o(0, 2, 1, 0, 0));
        add(4'b0000, o(1, 2, 0, 1, 0));
        add(4'b0100, o(0, 3, 1, 0, 1));
        add(4'b0000, o(0, 3, 1, 0, 0));
        add(4'b0000, o(1, 3, 0, 1, 0));
        // Test 2: next wraps 3 -> 0
        add(4'b0100, o(0, 0, 1, 0, 1));
        add(4'b0000, o(0, 0, 1, 0, 0));
        add(4'b0000, o(1, 0, 0, 1, 0));
        // Test 3: pause, prev wraps 0 -> 3 and lands in idle
        add(4'b1000, o(0, 0, 0, 0, 0));
        add(4'b0000, o(0, 0, 0, 0, 0));
        add(4'b0010, o(0, 3, 1, 0, 1));
        add(4'b0000, o(0, 3, 1, 0, 0));
        add(4'b0000, o(0, 3, 0, 0, 0));
        add(4'b0000, o(0, 3, 0, 0, 0));
        add(4'b1110, o(1, 3, 0, 1, 0));
        add(4'b0000, o(1, 3, 0, 1, 0));
        // Test 4: song_done on last song
        add(4'b0001, o(0, 0, 1, 0, 1));
        add(4'b0000, o(0, 0, 1, 0, 0));
        add(4'b0000, o(1, 0, 0, 1, 0));
        // Test 5: pause ignores song_done; edge in last flush cycle is dropped
        add(4'b1000, o(0, 0, 0, 0, 0));
        add(4'b0001, o(0, 0, 0, 0, 0));
        add(4'b0000, o(0, 0, 0, 0, 0));
        add(4'b1000, o(1, 0, 0, 1, 0));
        add(4'b0000, o(1, 0, 0, 1, 0));
        add(4'b0100, o(0, 1, 1, 0, 1));
        add(4'b0000, o(0, 1, 1, 0, 0));
        add(4'b0100, o(1, 1, 0, 1, 0));
        add(4'b0000, o(1, 1, 0, 1, 0));
        for (int i = 0; i <= 24; i++) vecs[i].chk_nl = 1'b1;
        vecs[22].exp_nl = o(0, 3, 1, 0, 0);
        vecs[23].exp_nl = o(0, 3, 1, 0, 0);
        vecs[24].exp_nl = o(0, 3, 0, 0, 0);

        reset = 1'b0;
        repeat (2) @(negedge clk);
        cmp("reset_state", act_main(), o(0, 0, 0, 0, 0));
        cmp("reset_state_nl", act_nl(), o(0, 0, 0, 0, 0));
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            sb.push_back(vecs[i]);
            @(negedge clk);
            v = sb.pop_front();
            cmp($sformatf("vec%0d", i), act_main(), v.exp);
            if (v.chk_nl) cmp($sformatf("vec%0d_noloop", i), act_nl(), v.exp_nl);
        end

        // Test 6: reset asserted during the second flush cycle
        drive(4'b0100);
        sb.push_back('{4'b0100, o(0, 2, 1, 0, 1), o(0, 2, 1, 0, 1), 1'b0});
        @(negedge clk);
        v = sb.pop_front();
        cmp("flush_c1", act_main(), v.exp);
        drive(4'b0000);
        sb.push_back('{4'b0000, o(0, 2, 1, 0, 0), o(0, 2, 1, 0, 0), 1'b0});
        @(negedge clk);
        v = sb.pop_front();
        cmp("flush_c2", act_main(), v.exp);
        #2 reset = 1'b0;
        #1 cmp("async_reset", act_main(), o(0, 0, 0, 0, 0));
        cmp("async_reset_nl", act_nl(), o(0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cmp("post_reset_idle", act_main(), o(0, 0, 0, 0, 0));
        drive(4'b1000);
        sb.push_back('{4'b1000, o(1, 0, 0, 1, 0), o(1, 0, 0, 1, 0), 1'b0});
        @(negedge clk);
        v = sb.pop_front();
        cmp("post_reset_play", act_main(), v.exp);
        drive(4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
